write_back_ctrl: RTL and testbench

WRITE_BACK_CTRL -- requirements
Module: write_back_ctrl

---
 rtl/wb_ctrl_pkg.sv | 23 ++
 rtl/wb_diag_counter.sv | 64 ++++++
 rtl/write_back_ctrl.sv | 163 ++++++++++++++++
 tb/tb_write_back_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the systolic-array write-back controller.
// Used by write_back_ctrl and wb_diag_counter.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Two result matrices are drained back to back.
  localparam int unsigned NUM_SETS = 2;

  // Fill counter must reach FILL_LATENCY, whose legal maximum is 255.
  localparam int unsigned FILL_CNT_W = 8;

  // An N x N array produces 2N-1 anti-diagonals, indexed 0..2N-2.
  function automatic int unsigned last_index(input int unsigned array_size);
    return (2 * array_size) - 2;
  endfunction

endpackage

// File: rtl/wb_diag_counter.sv
// Diagonal index / matrix-set counter for the write-back drain. Holds on
// stall, clears on request, and flags the final diagonal of the final set.
module wb_diag_counter
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 32,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 clr,
  input  logic                 step,
  input  logic                 hold,
  output logic [IDX_WIDTH-1:0] idx,
  output logic [1:0]           set_sel,
  output logic                 drain_wrap
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(last_index(ARRAY_SIZE));
  localparam logic [1:0]           LAST_SET = 2'(NUM_SETS - 1);

  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]           set_q, set_d;
  logic                 at_last_idx;
  logic                 advance;

  assign at_last_idx = (idx_q == LAST_IDX);
  assign advance     = step && !hold;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    idx_d = idx_q;
    set_d = set_q;
    if (clr) begin
      idx_d = '0;
      set_d = '0;
    end else if (advance) begin
      if (at_last_idx) begin
        idx_d = '0;
        set_d = (set_q == LAST_SET) ? 2'd0 : set_q + 2'd1;
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      idx_q <= '0;
      set_q <= '0;
    end else begin
      idx_q <= idx_d;
      set_q <= set_d;
    end
  end

  assign idx        = idx_q;
  assign set_sel    = set_q;
  assign drain_wrap = at_last_idx && (set_q == LAST_SET);

endmodule

// File: rtl/write_back_ctrl.sv
// Write-back controller: waits out the array fill latency, then drains two
// result matrices diagonal by diagonal. Optional stall counter: WB_STALL_CNT_EN.
module write_back_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE   = 32,
  parameter int unsigned FILL_LATENCY = 32,
  parameter int unsigned IDX_WIDTH    = 6
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 stall,
  output logic                 sram_write_enable,
  output logic [1:0]           data_set,
  output logic [IDX_WIDTH-1:0] matrix_index,
  output logic                 busy,
`ifdef WB_STALL_CNT_EN
  output logic                 done,
  output logic [15:0]          stall_cycles
`else
  output logic                 done
`endif
);

  localparam logic [FILL_CNT_W-1:0] FILL_LAST = FILL_CNT_W'(FILL_LATENCY);

  wb_state_e             state_q, state_d;
  logic [FILL_CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  run_q;
  logic                  start_ok;
  logic                  cnt_clr;
  logic                  cnt_step;
  logic                  drain_wrap;

  // NOTE: reset asserts asynchronously, but its release only reaches the FSM
  // through this flop, so start is first honoured on the second edge.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign start_ok = (state_q == ST_IDLE) && start && run_q;
  assign cnt_clr  = start_ok ||
                    (abort && ((state_q == ST_FILL) || (state_q == ST_DRAIN)));
  assign cnt_step = (state_q == ST_DRAIN) && !abort;

  wb_diag_counter #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_diag_counter (
    .clk        (clk),
    .srstn      (srstn),
    .clr        (cnt_clr),
    .step       (cnt_step),
    .hold       (stall),
    .idx        (matrix_index),
    .set_sel    (data_set),
    .drain_wrap (drain_wrap)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d    = ST_IDLE;
          fill_cnt_d = '0;
          busy_d     = 1'b0;
        end else if (fill_cnt_q == FILL_LAST) begin
          state_d = ST_DRAIN;
          wr_en_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + FILL_CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // Abort beats stall; a stalled cycle simply leaves the enable low.
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (!stall) begin
          if (drain_wrap) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            wr_en_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sram_write_enable = wr_en_q;
  assign busy              = busy_q;
  assign done              = done_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_DRAIN) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_write_back_ctrl.sv
// Self-checking bench for write_back_ctrl: behavioural drain model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_write_back_ctrl;

  localparam int N   = 32;
  localparam int LAT = 32;
  localparam int IW  = 6;
  localparam int D   = 2 * N - 1;   // diagonals per matrix

  logic          clk   = 1'b0;
  logic          srstn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          sram_write_enable;
  logic [1:0]    data_set;
  logic [IW-1:0] matrix_index;
  logic          busy;
  logic          done;
`ifdef WB_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  write_back_ctrl #(
    .ARRAY_SIZE   (N),
    .FILL_LATENCY (LAT),
    .IDX_WIDTH    (IW)
  ) dut (
    .clk               (clk),
    .srstn             (srstn),
    .start             (start),
    .abort             (abort),
    .stall             (stall),
    .sram_write_enable (sram_write_enable),
    .data_set          (data_set),
    .matrix_index      (matrix_index),
    .busy              (busy),
    .done              (done)
`ifdef WB_STALL_CNT_EN
    , .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase plus "cycles since start" and "diagonals written so far" (k);
  // the expected index/set are simply k mod D and k div D.
  typedef enum int {M_IDLE, M_FILL, M_DRAIN, M_DONE} m_phase_e;
  m_phase_e m_phase  = M_IDLE;
  bit       m_ready  = 1'b0;
  bit       m_en     = 1'b0;
  int       m_t      = 0;
  int       m_k      = 0;
  int       m_stalls = 0;
  int       m_run_id = 0;

  always @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      m_phase  = M_IDLE;
      m_ready  = 1'b0;
      m_en     = 1'b0;
      m_t      = 0;
      m_k      = 0;
      m_stalls = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (start && m_ready) begin
          m_phase  = M_FILL;
          m_t      = 0;
          m_stalls = 0;
          m_run_id++;
        end
        M_FILL: if (abort) begin
          m_phase = M_IDLE;
        end else begin
          m_t++;
          if (m_t == LAT + 1) begin
            m_phase = M_DRAIN;
            m_k     = 0;
            m_en    = 1'b1;
          end
        end
        M_DRAIN: begin
          if (stall && m_stalls < 65535) m_stalls++;
          if (abort) begin
            m_phase = M_IDLE;
            m_en    = 1'b0;
          end else if (stall) begin
            m_en = 1'b0;
          end else begin
            m_k++;
            if (m_k == 2 * D) begin
              m_phase = M_DONE;
              m_en    = 1'b0;
            end else begin
              m_en = 1'b1;
            end
          end
        end
        default: m_phase = M_IDLE;
      endcase
      m_ready = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int tot_en   = 0;
  int tot_done = 0;
  int run_en   = 0;
  int seen_run = 0;

  always @(negedge clk) begin
    if (m_run_id != seen_run) begin
      seen_run = m_run_id;
      run_en   = 0;
    end
    check("sram_write_enable", 32'(sram_write_enable), 32'(m_en));
    check("matrix_index", 32'(matrix_index), (m_phase == M_DRAIN) ? m_k % D : 0);
    check("data_set", 32'(data_set), (m_phase == M_DRAIN) ? m_k / D : 0);
    check("busy", 32'(busy), 32'(m_phase != M_IDLE));
    check("done", 32'(done), 32'(m_phase == M_DONE));
`ifdef WB_STALL_CNT_EN
    check("stall_cycles", 32'(stall_cycles), m_stalls);
`endif
    if (sram_write_enable) begin
      tot_en++;
      run_en++;
    end
    if (done) begin
      tot_done++;
      check("drain_enable_total", run_en, 2 * D);
    end
  end

  // ---------------- stimulus helpers (all end at posedge+1) ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_accept_busy", 32'(busy), 1);
  endtask

  task automatic wait_en(input int idx, input int set, input int budget,
                         output int cycles, output logic found);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (sram_write_enable && matrix_index == IW'(idx) && data_set == 2'(set)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_to_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic found;
    logic ok;
    int   en0;
    int   d0;

    #1 srstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_en", 32'(sram_write_enable), 0);
    check("reset_idx", 32'(matrix_index), 0);
    check("reset_set", 32'(data_set), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);

    // Release with start already high: edge 1 ignores it, edge 2 accepts.
    start = 1'b1;
    srstn = 1'b1;
    @(posedge clk); #1;
    check("start_edge1_ignored", 32'(busy), 0);
    @(posedge clk); #1;
    check("start_edge2_accepted", 32'(busy), 1);
    start = 1'b0;

    // Plain drain: latency, set hand-over, totals.
    en0 = tot_en;
    d0  = tot_done;
    wait_en(0, 0, 200, lat, found);
    check("first_en_found", 32'(found), 1);
    check("first_en_latency", lat, LAT + 1);
    wait_en(2 * N - 2, 0, 200, lat, found);
    check("set0_last_found", 32'(found), 1);
    @(posedge clk); #1;
    check("handover_en", 32'(sram_write_enable), 1);
    check("handover_idx", 32'(matrix_index), 0);
    check("handover_set", 32'(data_set), 1);
    run_to_idle(300, ok);
    check("plain_idle", 32'(ok), 1);
    check("plain_en_count", tot_en - en0, 126);
    check("plain_done_count", tot_done - d0, 1);

    // Stall for 3 cycles at set 0, index 10.
    do_start();
    en0 = tot_en;
    wait_en(10, 0, 200, lat, found);
    check("stall_idx10_found", 32'(found), 1);
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_en_low", 32'(sram_write_enable), 0);
      check("stall_idx_held", 32'(matrix_index), 10);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    check("stall_resume_idx", 32'(matrix_index), 11);
    check("stall_resume_en", 32'(sram_write_enable), 1);
    run_to_idle(300, ok);
    check("stall_idle", 32'(ok), 1);
    check("stall_en_count", tot_en - en0, 126);

    // Abort at set 1, index 40, then restart from the top.
    do_start();
    d0 = tot_done;
    wait_en(40, 1, 300, lat, found);
    check("abort_idx40_found", 32'(found), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_en", 32'(sram_write_enable), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_idx", 32'(matrix_index), 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", tot_done - d0, 0);
    do_start();
    en0 = tot_en;
    wait_en(0, 0, 200, lat, found);
    check("restart_found", 32'(found), 1);
    check("restart_latency", lat, LAT + 1);
    run_to_idle(300, ok);
    check("restart_en_count", tot_en - en0, 126);

    // Asynchronous reset at set 0, index 5.
    do_start();
    wait_en(5, 0, 200, lat, found);
    check("rst_idx5_found", 32'(found), 1);
    #1 srstn = 1'b0;
    #1;
    check("async_rst_en", 32'(sram_write_enable), 0);
    check("async_rst_idx", 32'(matrix_index), 0);
    check("async_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    @(posedge clk); #1;
    do_start();
    en0 = tot_en;
    run_to_idle(300, ok);
    check("post_rst_en_count", tot_en - en0, 126);

    // Start pulses during FILL, DRAIN and DONE are ignored.
    d0 = tot_done;
    do_start();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin
        start = 1'b1;
        @(posedge clk); #1;
        check("done_start_ignored", 32'(busy), 0);
        start = 1'b0;
        break;
      end
      start = 1'($urandom_range(0, 1));
    end
    check("noise_done_count", tot_done - d0, 1);

    // Stall counting: idle stalls are not counted, 7 drain stalls are.
    stall = 1'b1;
    repeat (4) @(posedge clk);
    #1 stall = 1'b0;
    do_start();
    wait_en(20, 0, 200, lat, found);
    check("cnt_idx20_found", 32'(found), 1);
    stall = 1'b1;
    repeat (4) @(posedge clk);
    #1 stall = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    run_to_idle(300, ok);
    check("cnt_idle", 32'(ok), 1);
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
`ifdef WB_STALL_CNT_EN
    check("stall_cycles_after_done", 32'(stall_cycles), 7);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      stall = ($urandom_range(0, 99) < 25);
      start = ($urandom_range(0, 99) < 8);
      abort = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    run_to_idle(400, ok);
    check("random_idle", 32'(ok), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
